// File: rtl/flex_counter_ud.sv
// flex_counter_ud: bidirectional counter with preload, selectable wrap base, one-shot stop,
// registered terminal/wrap flags and a saturating wrap-event counter.
module flex_counter_ud #(
   parameter int NUM_CNT_BITS  = 4,
   parameter int WRAP_TO_ZERO  = 0,
   parameter int WRAP_CNT_BITS = 8
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     clear_i,
   input  logic                     load_i,
   input  logic [NUM_CNT_BITS-1:0]  load_val_i,
   input  logic                     count_enable_i,
   input  logic                     count_up_i,
   input  logic                     one_shot_i,
   input  logic [NUM_CNT_BITS-1:0]  rollover_val_i,
   output logic [NUM_CNT_BITS-1:0]  count_out_o,
   output logic                     rollover_flag_o,
   output logic                     wrap_pulse_o,
   output logic                     done_o,
   output logic [WRAP_CNT_BITS-1:0] wrap_cnt_o
);
   localparam logic [NUM_CNT_BITS-1:0] BASE = (WRAP_TO_ZERO != 0) ? '0 : NUM_CNT_BITS'(1);
   logic [NUM_CNT_BITS-1:0]  count_q, count_d, term;
   logic [WRAP_CNT_BITS-1:0] wrap_cnt_q, wrap_cnt_d;
   logic                     rollover_q, wrap_q, done_q;
   logic                     hold, step, wrap;
   always_comb begin
      term       = count_up_i ? rollover_val_i : BASE;
      hold       = one_shot_i && (count_q == term);
      step       = count_enable_i && !clear_i && !load_i && !hold;
      // Down-counting reloads from BASE and also from 0, so BASE=1 never underflows
      wrap       = step && (count_up_i ? (count_q == rollover_val_i)
                                       : (count_q == BASE || count_q == '0));
      count_d    = clear_i ? '0 :
                   load_i  ? load_val_i :
                   !step   ? count_q :
                   wrap    ? (count_up_i ? BASE : rollover_val_i) :
                   count_up_i ? count_q + NUM_CNT_BITS'(1) : count_q - NUM_CNT_BITS'(1);
      wrap_cnt_d = (clear_i || load_i)      ? '0 :
                   (wrap && !(&wrap_cnt_q)) ? wrap_cnt_q + WRAP_CNT_BITS'(1) : wrap_cnt_q;
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q    <= '0;
         rollover_q <= 1'b0;
         wrap_q     <= 1'b0;
         done_q     <= 1'b0;
         wrap_cnt_q <= '0;
      end else begin
         count_q    <= count_d;
         rollover_q <= (count_d == term);
         wrap_q     <= wrap;
         done_q     <= one_shot_i && (count_d == term);
         wrap_cnt_q <= wrap_cnt_d;
      end
   end
   assign count_out_o     = count_q;
   assign rollover_flag_o = rollover_q;
   assign wrap_pulse_o    = wrap_q;
   assign done_o          = done_q;
   assign wrap_cnt_o      = wrap_cnt_q;
endmodule

// File: doc/flex_counter_ud.md
# flex_counter_ud

Parametrised up/down successor to the team's flex counter, used wherever a timer, bit counter or byte counter needs bidirectional counting, preload, selectable wrap base and a one-shot stop. The block holds a binary count with a programmable terminal value, registered terminal and wrap flags, and a saturating wrap-event counter. It is drop-in compatible with the legacy counter when `WRAP_TO_ZERO=0`, `count_up=1`, `load=0` and `one_shot=0`.

## Interface
- `NUM_CNT_BITS`, default 4: width of the count, `load_val` and `rollover_val`.
- `WRAP_TO_ZERO`, default 0: wrap base `BASE`. 0 gives `BASE=1` (legacy behaviour); 1 gives `BASE=0`.
- `WRAP_CNT_BITS`, default 8: width of the `wrap_cnt` counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `clear`  in  1  synchronous clear to 0; highest priority.
- `load`  in  1  synchronous preload of `load_val`; second priority.
- `load_val`  in  NUM_CNT_BITS  preload value.
- `count_enable`  in  1  advance the count by one step; third priority.
- `count_up`  in  1  direction: 1 counts up, 0 counts down.
- `one_shot`  in  1  1 stops at the terminal value instead of wrapping.
- `rollover_val`  in  NUM_CNT_BITS  up-count terminal and down-count reload value.
- `count_out`  out  NUM_CNT_BITS  current count.
- `rollover_flag`  out  1  registered; high while `count_out` equals the current terminal.
- `wrap_pulse`  out  1  registered; one-cycle pulse following each wrap.
- `done`  out  1  registered; high while in one-shot mode at the terminal.
- `wrap_cnt`  out  WRAP_CNT_BITS  saturating number of wraps since the last clear or load.

## Operation
- Terminal value TERM: `rollover_val` when `count_up=1`, `BASE` when `count_up=0`. TERM is evaluated with the `count_up` value sampled at the same edge.
- Next-count priority:
  - `clear=1`: next count is 0.
  - `load=1`: next count is `load_val`.
  - `count_enable=1`:
    - If `one_shot=1` and `count_out==TERM`, the count holds.
    - Up, `count_out==rollover_val`: next count is `BASE`; this is a wrap.
    - Up, otherwise: `count_out+1`, modulo 2^NUM_CNT_BITS. Passing from all-ones to 0 is not a wrap.
    - Down, `count_out==BASE` or `count_out==0`: next count is `rollover_val`; this is a wrap.
    - Down, otherwise: `count_out-1`.
  - Otherwise the count holds.
- Flag rules, all computed from next-state values:
  - `rollover_flag <= (next_count == TERM)`.
  - `done <= one_shot & (next_count == TERM)`.
  - `wrap_pulse <= wrap`.
- `wrap_cnt`:
  - `clear` or `load` resets it to 0.
  - Each wrap adds 1; the value saturates at all-ones.
- Changing `count_up` or `one_shot` while `done=1` re-evaluates TERM and the hold rule. Counting resumes on the next enabled cycle if the count is no longer at TERM.
- `rollover_val < BASE` gets no special handling; the rules above apply unchanged.
- Asserting `clear` or `load` while `count_enable=1` suppresses the wrap and `wrap_pulse` for that cycle.

## Timing
- Reset values: `count_out=0`, `rollover_flag=0`, `wrap_pulse=0`, `done=0`, `wrap_cnt=0`.
- Reset takes effect immediately when `n_rst` falls, including mid-count and mid-one-shot. The first update happens on the first rising edge after `n_rst` rises.
- Latency: every output changes on the same edge that consumes its inputs, so all outputs share zero-cycle alignment with `count_out`.
- `rollover_flag` and `done` rise on the same edge that `count_out` reaches TERM, whether by counting, load or clear.
- `wrap_pulse` is high exactly one cycle, during the cycle in which `count_out` holds the post-wrap value. Back-to-back wraps (`rollover_val==BASE`, or `rollover_val=0` counting down) keep it high continuously.
- All inputs are synchronous and are sampled only at the rising edge. There are no combinational input-to-output paths.

## Test plan
- Legacy mode: N=4, `WRAP_TO_ZERO=0`, `rollover_val=5`, up, enable held for 7 cycles.
  - Required: `count_out` 1,2,3,4,5,1,2.
  - Required: `rollover_flag` high only while the count is 5.
  - Required: `wrap_pulse` high while the count shows the post-wrap 1.
  - Required: `wrap_cnt=1` afterwards.
- Down count: `WRAP_TO_ZERO=1`, `rollover_val=3`, load 2, `count_up=0`, enable held for 5 cycles.
  - Required: `count_out` 1,0,3,2,1.
  - Required: `rollover_flag` high at 0.
  - Required: one `wrap_pulse`, at the count of 3.
- One-shot: `rollover_val=4`, `one_shot=1`, clear, then enable held for 8 cycles.
  - Required: count 1,2,3,4, then holds at 4.
  - Required: `done=1` from the edge the count reaches 4.
  - Required: no `wrap_pulse`.
  - Then switch to `count_up=0`: `done` falls and the count runs 3,2,...
- Priority: `clear`, `load=1` with `load_val=9`, and enable asserted together.
  - Required: `count_out=0`.
  - Next cycle, `load` plus enable: required `count_out=9`, `wrap_cnt=0`.
- Saturation: `WRAP_CNT_BITS=2`, `rollover_val=1`, `BASE=0`, enable held for 20 cycles.
  - Required: `wrap_cnt` reaches 3 and stays at 3.
  - Required: `wrap_pulse` toggles in step with the wraps.
- Reset mid-operation: drop `n_rst` asynchronously between edges while the count is 3 and `done=1`.
  - Required: all outputs go to 0 immediately, before the next edge.
  - Required: counting restarts from 0 after `n_rst` is released.
